// File: rtl/rvfi_pkg.sv
// Shared RVFI record types for the commit-to-tracer path.
// Types only: no logic, so there is no latency or backpressure behaviour here.
package rvfi_pkg;

    localparam int XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [31:0]       insn;
        logic              trap;
        logic              halt;
        logic              intr;
        logic [1:0]        mode;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_commit_t;

    typedef struct packed {
        rvfi_commit_t commit;
        logic [63:0]  order;
        logic [63:0]  cycle_cnt;
    } rvfi_record_t;

endpackage

// File: rtl/rvfi_mw_fifo.sv
// NRET-write / 1-read record FIFO; written entries are readable one cycle later.
// wr_rdy depends on registered occupancy only; a pop never frees space in the same cycle.
module rvfi_mw_fifo
    import rvfi_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [$clog2(NRET+1)-1:0]    wr_cnt,
    input  rvfi_record_t [NRET-1:0]      wr_dat,
    output logic                         wr_rdy,
    output logic                         rd_vld,
    output rvfi_record_t                 rd_dat,
    input  logic                         rd_rdy,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rvfi_record_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    assign wr_rdy = (count_q <= CW'(DEPTH - NRET));
    assign push   = wr_rdy && (wr_cnt != '0);
    assign rd_vld = (count_q != '0);
    assign pop    = rd_vld && rd_rdy;
    assign count  = count_q;

    // Stale storage survives reset, so the head is masked while empty.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // Compacted slots land at consecutive addresses; the pointer add wraps naturally.
    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int i = 0; i < NRET; i++) begin
                if (i < int'(wr_cnt)) begin
                    mem[wr_ptr + AW'(i)] <= wr_dat[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(wr_cnt);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + (push ? CW'(wr_cnt) : CW'(0)) - CW'(pop);
        end
    end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Compacts NRET commit lanes into one in-order, order/cycle-stamped RVFI stream; 1-cycle min latency.
// commit_ready_o is all-or-nothing from registered occupancy; out_o holds while out_ready_i is low.
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NRET-1:0]           commit_valid_i,
    input  rvfi_commit_t [NRET-1:0]   commit_i,
    output logic                      commit_ready_o,
    output logic                      out_valid_o,
    output rvfi_record_t              out_o,
    input  logic                      out_ready_i,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int NW = $clog2(NRET + 1);

    logic [63:0]              cycle_q;
    logic [63:0]              order_q;
    logic [NW-1:0]            rank [NRET];
    logic [NW-1:0]            n_valid;
    logic [NW-1:0]            wr_cnt;
    logic                     accept;
    rvfi_record_t [NRET-1:0]  slot_dat;

    // rank[i] = number of valid lanes below lane i, i.e. its compacted slot.
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < NRET; i++) begin
            rank[i] = n_valid;
            n_valid = n_valid + NW'(commit_valid_i[i]);
        end
    end

    always_comb begin
        slot_dat = '0;
        for (int j = 0; j < NRET; j++) begin
            slot_dat[j].order     = order_q + 64'(j);
            slot_dat[j].cycle_cnt = cycle_q;
            for (int i = 0; i < NRET; i++) begin
                if (commit_valid_i[i] && (rank[i] == NW'(j))) begin
                    slot_dat[j].commit = commit_i[i];
                end
            end
        end
    end

    assign accept = commit_ready_o && (commit_valid_i != '0);
    assign wr_cnt = accept ? n_valid : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q <= '0;
            order_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (accept) begin
                order_q <= order_q + 64'(n_valid);
            end
        end
    end

    rvfi_mw_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_cnt (wr_cnt),
        .wr_dat (slot_dat),
        .wr_rdy (commit_ready_o),
        .rd_vld (out_valid_o),
        .rd_dat (out_o),
        .rd_rdy (out_ready_i),
        .count  (count_o)
    );

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Randomised and directed bench for rvfi_commit_serializer against a queue-based reference model.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic [NRET-1:0]          commit_valid_i;
    rvfi_commit_t [NRET-1:0]  commit_i;
    logic                     commit_ready_o;
    logic                     out_valid_o;
    rvfi_record_t             out_o;
    logic                     out_ready_i;
    logic [$clog2(DEPTH):0]   count_o;

    rvfi_commit_serializer #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .commit_valid_i (commit_valid_i),
        .commit_i       (commit_i),
        .commit_ready_o (commit_ready_o),
        .out_valid_o    (out_valid_o),
        .out_o          (out_o),
        .out_ready_i    (out_ready_i),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    rvfi_record_t q[$];
    logic [63:0]  m_order;
    logic [63:0]  m_cyc;
    logic [63:0]  next_pc;
    bit           last_stall;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic rvfi_commit_t rand_commit(input logic [63:0] pc);
        rvfi_commit_t c;
        logic [31:0]  r;
        r           = $urandom;
        c.pc_rdata  = pc;
        c.pc_wdata  = pc + 64'd4;
        c.insn      = $urandom;
        c.trap      = r[0];
        c.halt      = r[1];
        c.intr      = r[2];
        c.mode      = r[4:3];
        c.rd_addr   = r[9:5];
        c.rd_wdata  = {$urandom, $urandom};
        c.mem_addr  = {$urandom, $urandom};
        c.mem_rmask = r[17:10];
        c.mem_wmask = r[25:18];
        c.mem_rdata = {$urandom, $urandom};
        c.mem_wdata = {$urandom, $urandom};
        return c;
    endfunction

    task automatic check_outputs();
        rvfi_record_t h;
        bit           exp_vld;
        exp_vld = (q.size() != 0);
        chk("out_valid", 64'(out_valid_o), 64'(exp_vld));
        chk("count", 64'(count_o), 64'(q.size()));
        chk("commit_ready", 64'(commit_ready_o), 64'((DEPTH - q.size()) >= NRET));
        if (exp_vld) begin
            h = q[0];
            chk("pc_rdata", out_o.commit.pc_rdata, h.commit.pc_rdata);
            chk("pc_wdata", out_o.commit.pc_wdata, h.commit.pc_wdata);
            chk("insn", 64'(out_o.commit.insn), 64'(h.commit.insn));
            chk("rd_wdata", out_o.commit.rd_wdata, h.commit.rd_wdata);
            chk("mem_addr", out_o.commit.mem_addr, h.commit.mem_addr);
            chk("mem_rdata", out_o.commit.mem_rdata, h.commit.mem_rdata);
            chk("mem_wdata", out_o.commit.mem_wdata, h.commit.mem_wdata);
            chk("misc", 64'({out_o.commit.trap, out_o.commit.halt, out_o.commit.intr, out_o.commit.mode,
                             out_o.commit.rd_addr, out_o.commit.mem_rmask, out_o.commit.mem_wmask}),
                        64'({h.commit.trap, h.commit.halt, h.commit.intr, h.commit.mode,
                             h.commit.rd_addr, h.commit.mem_rmask, h.commit.mem_wmask}));
            chk("order", out_o.order, h.order);
            chk("cycle_cnt", out_o.cycle_cnt, h.cycle_cnt);
        end
    endtask

    // Reference: unbounded in-order queue, space rule on pre-pop size, lanes stamped in ascending index.
    task automatic model_step();
        rvfi_record_t r;
        bit           rdy;
        bit           pop;
        if (rst_i) begin
            q.delete();
            m_order    = '0;
            m_cyc      = '0;
            last_stall = 1'b0;
            return;
        end
        rdy        = (DEPTH - q.size()) >= NRET;
        pop        = (q.size() != 0) && out_ready_i;
        last_stall = (commit_valid_i != '0) && !rdy;
        if (pop) void'(q.pop_front());
        if (rdy) begin
            for (int i = 0; i < NRET; i++) begin
                if (commit_valid_i[i]) begin
                    r.commit    = commit_i[i];
                    r.order     = m_order;
                    r.cycle_cnt = m_cyc;
                    q.push_back(r);
                    m_order = m_order + 64'd1;
                end
            end
        end
        m_cyc = m_cyc + 64'd1;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        if (!rst_i) check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [NRET-1:0] v);
        if (last_stall) return;
        commit_valid_i = v;
        for (int i = 0; i < NRET; i++) begin
            if (v[i]) begin
                commit_i[i] = rand_commit(next_pc);
                next_pc     = next_pc + 64'd4;
            end else begin
                commit_i[i] = rand_commit(64'hdead_0000);
            end
        end
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        commit_valid_i = '0;
        out_ready_i    = 1'b0;
        cycle();
        rst_i = 1'b0;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_commit_ready", 64'(commit_ready_o), 64'd1);
        chk("rst_out_zero", 64'(out_o == '0), 64'd1);
    endtask

    task automatic drain(input int n);
        commit_valid_i = '0;
        out_ready_i    = 1'b1;
        repeat (n) cycle();
    endtask

    initial begin
        int total;
        rst_i          = 1'b1;
        commit_valid_i = '0;
        commit_i       = '0;
        out_ready_i    = 1'b0;
        next_pc        = 64'h1000;
        last_stall     = 1'b0;
        @(negedge clk);

        // Single record stamped with cycle 5
        do_reset();
        repeat (5) cycle();
        next_pc = 64'h8000_0000;
        drive(2'b01);
        cycle();
        commit_valid_i = '0;
        chk("single_vld", 64'(out_valid_o), 64'd1);
        chk("single_pc", out_o.commit.pc_rdata, 64'h8000_0000);
        chk("single_order", out_o.order, 64'd0);
        chk("single_cyc", out_o.cycle_cnt, 64'd5);
        drain(3);

        // Sparse lanes
        do_reset();
        next_pc = 64'h100;
        drive(2'b10);
        cycle();
        drive(2'b11);
        cycle();
        commit_valid_i = '0;
        out_ready_i    = 1'b1;
        chk("sparse_pc0", out_o.commit.pc_rdata, 64'h100);
        chk("sparse_ord0", out_o.order, 64'd0);
        chk("sparse_cc0", out_o.cycle_cnt, 64'd0);
        cycle();
        chk("sparse_pc1", out_o.commit.pc_rdata, 64'h104);
        chk("sparse_ord1", out_o.order, 64'd1);
        chk("sparse_cc1", out_o.cycle_cnt, 64'd1);
        cycle();
        chk("sparse_pc2", out_o.commit.pc_rdata, 64'h108);
        chk("sparse_ord2", out_o.order, 64'd2);
        chk("sparse_cc2", out_o.cycle_cnt, 64'd1);
        drain(2);

        // Back-pressure to full, then release with the producer still pushing
        do_reset();
        next_pc = 64'h2000;
        for (int k = 0; k < 7; k++) begin
            drive(2'b11);
            cycle();
        end
        chk("full_count", 64'(count_o), 64'(DEPTH));
        chk("full_ready", 64'(commit_ready_o), 64'd0);
        chk("full_head_pc", out_o.commit.pc_rdata, 64'h2000);
        out_ready_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(2'b11);
            cycle();
        end
        drain(12);

        // Twenty records across the pointer wrap with toggling out_ready_i
        do_reset();
        next_pc = 64'h3000;
        total   = 0;
        for (int k = 0; k < 200 && total < 20; k++) begin
            out_ready_i = k[0];
            drive(2'($urandom_range(1, 3)));
            if (commit_ready_o) total += int'(commit_valid_i[0]) + int'(commit_valid_i[1]);
            cycle();
        end
        drain(12);
        next_pc = 64'h3800;
        drive(2'b01);
        cycle();
        commit_valid_i = '0;
        chk("wrap_next_order", out_o.order, 64'(total));
        drain(2);

        // Reset with five records buffered
        out_ready_i = 1'b0;
        next_pc     = 64'h4000;
        drive(2'b11); cycle();
        drive(2'b11); cycle();
        drive(2'b01); cycle();
        commit_valid_i = '0;
        chk("mid_count", 64'(count_o), 64'd5);
        do_reset();
        drive(2'b01);
        cycle();
        commit_valid_i = '0;
        chk("post_rst_vld", 64'(out_valid_o), 64'd1);
        chk("post_rst_order", out_o.order, 64'd0);
        drain(2);

        // Order counter wrap
        do_reset();
        force dut.order_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_order = 64'hFFFF_FFFF_FFFF_FFFF;
        next_pc = 64'h5000;
        drive(2'b11);
        cycle();
        release dut.order_q;
        commit_valid_i = '0;
        out_ready_i    = 1'b1;
        chk("wrap_ord_max", out_o.order, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        chk("wrap_ord_zero", out_o.order, 64'd0);
        cycle();

        // Random traffic with one reset in the middle
        do_reset();
        next_pc = 64'h1_0000;
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) do_reset();
            out_ready_i = ($urandom_range(0, 9) < 7);
            drive(2'($urandom_range(0, 3)));
            cycle();
        end
        drain(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
